// File: rtl/ecall_halt_ctrl_pkg.sv
// Shared constants for the ECALL halt controller: opcode, FSM encoding, register index.
package ecall_halt_ctrl_pkg;

  localparam logic [6:0] ECALL = 7'b1110011;

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  localparam logic [4:0] X17 = 5'd17;

endpackage

// File: rtl/ecall_halt_ctrl_x17_halt_resolve.sv
// Resolves whether the x17 seen by the ECALL in ID/EX equals the halt code,
// letting the youngest in-flight producer of x17 win.
module x17_halt_resolve
  import ecall_halt_ctrl_pkg::*;
#(
  parameter logic [31:0] HALT_CODE = 32'd10
) (
  input  logic        ex_mem_reg_write_i,
  input  logic [4:0]  ex_mem_rd_i,
  input  logic        is_ecall_fwd_i,
  input  logic        mem_wb_reg_write_i,
  input  logic [4:0]  mem_wb_rd_i,
  input  logic [31:0] mem_wb_wdata_i,
  input  logic [31:0] id_ex_x17_i,
  output logic        halt_cond_o
);

  always_comb begin
    if (ex_mem_reg_write_i && (ex_mem_rd_i == X17)) begin
      // EX/MEM already precomputed "writes x17 with halt code" as a flag.
      halt_cond_o = is_ecall_fwd_i;
    end else if (mem_wb_reg_write_i && (mem_wb_rd_i == X17)) begin
      halt_cond_o = (mem_wb_wdata_i == HALT_CODE);
    end else begin
      halt_cond_o = (id_ex_x17_i == HALT_CODE);
    end
  end

endmodule

// File: rtl/ecall_halt_ctrl.sv
// Detects a halt ECALL in ID/EX, stops fetch, drains older instructions to
// write-back, then raises a sticky is_halted.
module ecall_halt_ctrl
  import ecall_halt_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter logic [31:0] HALT_CODE    = 32'd10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_ex_valid,
  input  logic        id_ex_is_ecall,
  input  logic [31:0] id_ex_x17,
  input  logic        isecallForward,
  input  logic        ex_mem_reg_write,
  input  logic [4:0]  ex_mem_rd,
  input  logic        mem_wb_reg_write,
  input  logic [4:0]  mem_wb_rd,
  input  logic [31:0] mem_wb_wdata,
  output logic        stop_fetch,
  output logic        flush_if_id,
  output logic        halt_pending,
  output logic        is_halted,
  output logic [15:0] ecall_nonhalt_cnt
);

  localparam logic [2:0] DrainLoad = 3'(DRAIN_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] nonhalt_q, nonhalt_d;
  logic        halt_cond;
  logic        ecall_seen;

  assign ecall_seen = id_ex_valid && id_ex_is_ecall;

  x17_halt_resolve #(
    .HALT_CODE (HALT_CODE)
  ) u_resolve (
    .ex_mem_reg_write_i (ex_mem_reg_write),
    .ex_mem_rd_i        (ex_mem_rd),
    .is_ecall_fwd_i     (isecallForward),
    .mem_wb_reg_write_i (mem_wb_reg_write),
    .mem_wb_rd_i        (mem_wb_rd),
    .mem_wb_wdata_i     (mem_wb_wdata),
    .id_ex_x17_i        (id_ex_x17),
    .halt_cond_o        (halt_cond)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    nonhalt_d   = nonhalt_q;
    flush_if_id = 1'b1;
    case (state_q)
      RUN: begin
        flush_if_id = ecall_seen && halt_cond;
        if (ecall_seen) begin
          if (halt_cond) begin
            state_d = DRAIN;
            cnt_d   = DrainLoad;
          end else begin
            nonhalt_d = nonhalt_q + 16'd1;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == 3'd0) begin
          state_d = HALTED;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      HALTED: ;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      cnt_q     <= 3'd0;
      nonhalt_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      nonhalt_q <= nonhalt_d;
    end
  end

  assign stop_fetch        = (state_q != RUN);
  assign halt_pending      = (state_q == DRAIN);
  assign is_halted         = (state_q == HALTED);
  assign ecall_nonhalt_cnt = nonhalt_q;

endmodule
